// File: rtl/slvx_rx_buffer.sv
// Receive buffer for the arbiter's merged slvx_* stream: FWFT FIFO with registered
// almost-full back-pressure, sticky overflow flag and a per-frame completion pulse.
module slvx_rx_buffer #(
    parameter int DW           = 32,
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 2,
    parameter int FRAME_WORDS  = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               slvx_mode,
    input  logic                     slvx_data_valid,
    input  logic [7:0]               slvx_proc_val,
    input  logic [DW-1:0]            slvx_data,
    output logic                     fifo_full,
    output logic                     ovf_err,
    output logic                     pe_valid,
    input  logic                     pe_ready,
    output logic [DW-1:0]            pe_data,
    output logic [1:0]               pe_mode,
    output logic [7:0]               pe_proc_val,
    output logic [$clog2(DEPTH):0]   fill_cnt,
    output logic                     mstr0_cmplt
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int FCW = $clog2(FRAME_WORDS + 1);
    localparam int EW  = DW + 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        CMPLT  = 2'd2
    } state_t;

    logic [EW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  fill_cnt_q, fill_cnt_d;
    logic           fifo_full_q, fifo_full_d;
    logic           ovf_err_q, ovf_err_d;
    state_t         state_q, state_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           push, pop;
    logic [EW-1:0]  head;

    assign pe_valid = (fill_cnt_q != '0);
    assign pop      = pe_valid && pe_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = slvx_data_valid && ((fill_cnt_q != CW'(DEPTH)) || pop);

    // NOTE: every comb output gets a default first so no path through the block
    // leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_ptr_d    = rd_ptr_q + {{(AW-1){1'b0}}, pop};
        wr_ptr_d    = wr_ptr_q + {{(AW-1){1'b0}}, push};
        fill_cnt_d  = fill_cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        fifo_full_d = (fill_cnt_d >= CW'(DEPTH - AFULL_MARGIN));
        ovf_err_d   = ovf_err_q || (slvx_data_valid && !push);
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ACTIVE: begin
                if (pop) begin
                    if (frame_cnt_q == FCW'(FRAME_WORDS - 1)) begin
                        state_d     = CMPLT;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                // IDLE and CMPLT both start a new frame on a pop.
                if (state_q == CMPLT) state_d = IDLE;
                if (pop) begin
                    if (FRAME_WORDS == 1) begin
                        state_d     = CMPLT;
                        frame_cnt_d = '0;
                    end else begin
                        state_d     = ACTIVE;
                        frame_cnt_d = FCW'(1);
                    end
                end
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            fifo_full_q <= 1'b0;
            ovf_err_q   <= 1'b0;
            state_q     <= IDLE;
            frame_cnt_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            fifo_full_q <= fifo_full_d;
            ovf_err_q   <= ovf_err_d;
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // NOTE: the storage array has no reset; stale contents are never visible
    // because the head outputs are forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {slvx_mode, slvx_proc_val, slvx_data};
    end

    assign head = mem_q[rd_ptr_q];
    assign {pe_mode, pe_proc_val, pe_data} = pe_valid ? head : '0;

    assign fifo_full   = fifo_full_q;
    assign ovf_err     = ovf_err_q;
    assign fill_cnt    = fill_cnt_q;
    assign mstr0_cmplt = (state_q == CMPLT);

endmodule

// File: tb/tb_slvx_rx_buffer.sv
// Scoreboard bench for slvx_rx_buffer: a queue/counter reference model predicts
// occupancy, flags, frame pulses and pop order; a negedge monitor compares.
module tb_slvx_rx_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AFM   = 2;
    localparam int FW    = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [1:0]    mode;
        logic [7:0]    pv;
        logic [DW-1:0] data;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    slvx_mode = '0;
    logic          slvx_data_valid = 1'b0;
    logic [7:0]    slvx_proc_val = '0;
    logic [DW-1:0] slvx_data = '0;
    logic          fifo_full, ovf_err, pe_valid, mstr0_cmplt;
    logic          pe_ready = 1'b0;
    logic [DW-1:0] pe_data;
    logic [1:0]    pe_mode;
    logic [7:0]    pe_proc_val;
    logic [CW-1:0] fill_cnt;

    slvx_rx_buffer #(.DW(DW), .DEPTH(DEPTH), .AFULL_MARGIN(AFM), .FRAME_WORDS(FW)) dut (
        .clk(clk), .rst_n(rst_n),
        .slvx_mode(slvx_mode), .slvx_data_valid(slvx_data_valid),
        .slvx_proc_val(slvx_proc_val), .slvx_data(slvx_data),
        .fifo_full(fifo_full), .ovf_err(ovf_err),
        .pe_valid(pe_valid), .pe_ready(pe_ready),
        .pe_data(pe_data), .pe_mode(pe_mode), .pe_proc_val(pe_proc_val),
        .fill_cnt(fill_cnt), .mstr0_cmplt(mstr0_cmplt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: occupancy is a plain counter, ordering is the sb queue,
    // frame boundaries are every FW-th pop since reset.
    entry_t sb[$];
    int     occ;
    int     pops;
    logic   exp_full, exp_ovf, exp_cmplt;
    int     pulse_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ       = 0;
            pops      = 0;
            exp_full  = 1'b0;
            exp_ovf   = 1'b0;
            exp_cmplt = 1'b0;
            sb.delete();
        end else begin
            automatic bit m_pop  = pe_ready && (occ > 0);
            automatic bit m_push = slvx_data_valid && ((occ < DEPTH) || m_pop);
            if (slvx_data_valid && !m_push) exp_ovf = 1'b1;
            if (m_push) sb.push_back('{mode: slvx_mode, pv: slvx_proc_val, data: slvx_data});
            occ       = occ + int'(m_push) - int'(m_pop);
            exp_full  = (occ >= DEPTH - AFM);
            exp_cmplt = 1'b0;
            if (m_pop) begin
                pops++;
                if (pops % FW == 0) exp_cmplt = 1'b1;
            end
        end
    end

    logic   held_v = 1'b0;
    entry_t held_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            automatic entry_t cur = '{mode: pe_mode, pv: pe_proc_val, data: pe_data};
            check("pe_valid",    pe_valid,    (occ != 0));
            check("fill_cnt",    fill_cnt,    occ);
            check("fifo_full",   fifo_full,   exp_full);
            check("ovf_err",     ovf_err,     exp_ovf);
            check("mstr0_cmplt", mstr0_cmplt, exp_cmplt);
            if (mstr0_cmplt) pulse_cnt++;
            if (held_v && pe_valid) check("hold_stable", cur, held_e);
            held_v = pe_valid && !pe_ready;
            held_e = cur;
            if (pe_valid && pe_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_order: popped %0h but no word expected", cur);
                end else begin
                    check("pop_order", cur, sb.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [1:0] m,
                         input logic [7:0] pv, input logic r);
        slvx_data_valid = v;
        slvx_data       = d;
        slvx_mode       = m;
        slvx_proc_val   = pv;
        pe_ready        = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 2'd0, 8'd0, r);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_pe_valid"},  pe_valid,    1'b0);
        check({tag, "_fill_cnt"},  fill_cnt,    '0);
        check({tag, "_pe_head"},   {pe_mode, pe_proc_val, pe_data}, '0);
        check({tag, "_fifo_full"}, fifo_full,   1'b0);
        check({tag, "_ovf_err"},   ovf_err,     1'b0);
        check({tag, "_cmplt"},     mstr0_cmplt, 1'b0);
    endtask

    task automatic do_reset();
        slvx_data_valid = 1'b0;
        pe_ready        = 1'b0;
        rst_n           = 1'b0;
        #1;
        check_cleared("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        pulse_cnt = 0;
    endtask

    task automatic fill_n(input int n);
        for (int i = 0; i < n; i++) begin
            automatic logic [DW-1:0] w = DW'(i);
            drive(1'b1, w, w[1:0], w[7:0], 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // single word through an empty FIFO
        drive(1'b1, 32'hA5A5_0001, 2'd1, 8'hFF, 1'b1);
        idle(3, 1'b1);

        // fill to DEPTH, overflow push, drain
        do_reset();
        fill_n(DEPTH);
        check("full_fill_cnt", fill_cnt, DEPTH);
        drive(1'b1, 32'hDEAD_BEEF, 2'd3, 8'h5A, 1'b0);
        idle(DEPTH + 3, 1'b1);
        check("ovf_sticky", ovf_err, 1'b1);

        // push and pop together at full
        do_reset();
        fill_n(DEPTH);
        drive(1'b1, 32'h100, 2'd2, 8'h33, 1'b1);
        check("full_pushpop_cnt", fill_cnt, DEPTH);
        idle(DEPTH + 3, 1'b1);

        // two frames streamed back to back
        do_reset();
        for (int i = 0; i < 2 * FW; i++) drive(1'b1, $urandom, 2'($urandom_range(0, 3)), 8'($urandom), 1'b1);
        idle(4, 1'b1);
        check("two_frame_pulses", pulse_cnt, 2);

        // random valid / ready
        do_reset();
        for (int i = 0; i < 600; i++)
            drive(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), 8'($urandom),
                  ($urandom_range(0, 9) < 6));
        idle(DEPTH + 4, 1'b1);
        check("no_word_lost", sb.size(), 0);

        // asynchronous reset mid-frame discards the partial count
        do_reset();
        for (int i = 0; i < 31; i++) drive(1'b1, $urandom, 2'd0, 8'($urandom), 1'b1);
        check("partial_no_pulse", pulse_cnt, 0);
        #2;
        rst_n = 1'b0;
        slvx_data_valid = 1'b0;
        #1;
        check_cleared("midcycle");
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        pulse_cnt = 0;
        for (int i = 0; i < FW; i++) drive(1'b1, $urandom, 2'd1, 8'($urandom), 1'b1);
        idle(4, 1'b1);
        check("frame_after_reset", pulse_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
